// File: rtl/ifm_aux_write_port_pkg.sv
// Shared constants and FSM state encoding for the IFM aux write port.
package ifm_aux_write_port_pkg;

  localparam int FM_BUFFER_AW   = 12;
  localparam int IFM_DATA_W     = 32;
  localparam int AUX_FIFO_DEPTH = 16;
  localparam int AUX_FIFO_AW    = 4;
  localparam int AUX_CNT_W      = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } aux_state_e;

endpackage

// File: rtl/ifm_aux_write_port_sync_fifo.sv
// Register-based first-word-fall-through FIFO: rdata shows the head entry
// whenever the FIFO is not empty, so it can be consumed in the pop cycle.
module ifm_aux_write_port_sync_fifo
  import ifm_aux_write_port_pkg::*;
#(
  parameter int DW    = FM_BUFFER_AW + IFM_DATA_W,
  parameter int DEPTH = AUX_FIFO_DEPTH,
  parameter int AW    = AUX_FIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_pop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata  = mem[rd_ptr[AW-1:0]];
  assign do_pop = pop & ~empty;

  // Pointer update; reset discards every stored entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; a push into a full FIFO is only issued alongside a pop,
  // so it overwrites the slot being read out in the same cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ifm_aux_write_port.sv
// Merges the non-back-pressurable aux write stream into the IFM buffer write
// port behind the primary DRAM-fill writer, and tracks aux sessions.
module ifm_aux_write_port
  import ifm_aux_write_port_pkg::*;
#(
  parameter int IFM_AW     = FM_BUFFER_AW,
  parameter int IFM_DW     = IFM_DATA_W,
  parameter int FIFO_DEPTH = AUX_FIFO_DEPTH,
  parameter int FIFO_AW    = AUX_FIFO_AW,
  parameter int CNT_W      = AUX_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aux_vld,
  input  logic              aux_write_vld,
  input  logic [IFM_AW-1:0] aux_write_addr,
  input  logic [IFM_DW-1:0] aux_write_data,
  input  logic              main_wr_vld,
  input  logic [IFM_AW-1:0] main_wr_addr,
  input  logic [IFM_DW-1:0] main_wr_data,
  output logic              buf_we,
  output logic [IFM_AW-1:0] buf_addr,
  output logic [IFM_DW-1:0] buf_wdata,
  output logic              aux_busy,
  output logic              aux_done,
  output logic              aux_overflow,
  output logic [CNT_W-1:0]  aux_wr_cnt
);

  localparam int EW = IFM_AW + IFM_DW;

  aux_state_e        state;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EW-1:0]     fifo_head;
  logic [IFM_AW-1:0] head_addr;
  logic [IFM_DW-1:0] head_data;

  logic              wr_vld_p1;
  logic [IFM_AW-1:0] wr_addr_p1;
  logic [IFM_DW-1:0] wr_data_p1;
  logic              aux_commit_p1;

  // The main writer always wins the port; the FIFO drains only in its gaps.
  assign push_req = aux_vld & aux_write_vld;
  assign pop      = ~fifo_empty & ~main_wr_vld;
  assign push     = push_req & (~fifo_full | pop);
  assign drop     = push_req & fifo_full & ~pop;

  assign {head_addr, head_data} = fifo_head;

  ifm_aux_write_port_sync_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({aux_write_addr, aux_write_data}),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---- stage p1: registered buffer write port ----
  // Select main first, then the FIFO head; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_vld_p1     <= 1'b0;
      aux_commit_p1 <= 1'b0;
      wr_addr_p1    <= '0;
      wr_data_p1    <= '0;
    end else begin
      wr_vld_p1     <= main_wr_vld | pop;
      aux_commit_p1 <= pop;
      if (main_wr_vld) begin
        wr_addr_p1 <= main_wr_addr;
        wr_data_p1 <= main_wr_data;
      end else if (pop) begin
        wr_addr_p1 <= head_addr;
        wr_data_p1 <= head_data;
      end
    end
  end

  assign buf_we    = wr_vld_p1;
  assign buf_addr  = wr_addr_p1;
  assign buf_wdata = wr_data_p1;

  // Session FSM with commit counter, sticky overflow and done pulse.
  // The FIFO is always empty in IDLE, so the session-start clear never
  // races a pop or a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      aux_done     <= 1'b0;
      aux_overflow <= 1'b0;
      aux_wr_cnt   <= '0;
    end else begin
      aux_done <= 1'b0;
      if (pop)  aux_wr_cnt   <= aux_wr_cnt + 1'b1;
      if (drop) aux_overflow <= 1'b1;
      case (state)
        S_IDLE: begin
          if (aux_vld) begin
            state        <= S_ACTIVE;
            aux_wr_cnt   <= '0;
            aux_overflow <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (!aux_vld) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Re-assertion merges into the same session.
          if (aux_vld) begin
            state <= S_ACTIVE;
          end else if (fifo_empty && !aux_commit_p1) begin
            state    <= S_IDLE;
            aux_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign aux_busy = (state != S_IDLE);

endmodule

// File: tb/tb_ifm_aux_write_port.sv
// Self-checking bench for ifm_aux_write_port with a queue-based reference model.
module tb_ifm_aux_write_port;
  import ifm_aux_write_port_pkg::*;

  localparam int AW    = FM_BUFFER_AW;
  localparam int DW    = IFM_DATA_W;
  localparam int DEPTH = AUX_FIFO_DEPTH;
  localparam int CW    = AUX_CNT_W;
  localparam int VW    = AW + DW + CW + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          aux_vld = 1'b0;
  logic          aux_write_vld = 1'b0;
  logic [AW-1:0] aux_write_addr = '0;
  logic [DW-1:0] aux_write_data = '0;
  logic          main_wr_vld = 1'b0;
  logic [AW-1:0] main_wr_addr = '0;
  logic [DW-1:0] main_wr_data = '0;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_wdata;
  logic          aux_busy;
  logic          aux_done;
  logic          aux_overflow;
  logic [CW-1:0] aux_wr_cnt;

  ifm_aux_write_port dut (
    .clk            (clk),
    .rst            (rst),
    .aux_vld        (aux_vld),
    .aux_write_vld  (aux_write_vld),
    .aux_write_addr (aux_write_addr),
    .aux_write_data (aux_write_data),
    .main_wr_vld    (main_wr_vld),
    .main_wr_addr   (main_wr_addr),
    .main_wr_data   (main_wr_data),
    .buf_we         (buf_we),
    .buf_addr       (buf_addr),
    .buf_wdata      (buf_wdata),
    .aux_busy       (aux_busy),
    .aux_done       (aux_done),
    .aux_overflow   (aux_overflow),
    .aux_wr_cnt     (aux_wr_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending aux writes in arrival order plus expected outputs.
  logic [AW+DW-1:0] mq[$];
  logic             e_we;
  logic [AW-1:0]    e_addr;
  logic [DW-1:0]    e_data;
  logic [CW-1:0]    e_cnt;
  logic             e_ovf;
  logic             e_busy;
  logic             e_done;
  logic             m_closing;
  logic             m_pend;

  function automatic logic [VW-1:0] obs_vec();
    return {buf_we, buf_addr, buf_wdata, aux_wr_cnt, aux_overflow, aux_busy, aux_done};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_we, e_addr, e_data, e_cnt, e_ovf, e_busy, e_done};
  endfunction

  task automatic model_reset();
    mq.delete();
    e_we = 1'b0; e_addr = '0; e_data = '0; e_cnt = '0;
    e_ovf = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    m_closing = 1'b0; m_pend = 1'b0;
  endtask

  // One clock of the port's rules, evaluated from the pre-edge situation.
  task automatic model_step(input logic v, input logic wv, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic mv,
                            input logic [AW-1:0] ma, input logic [DW-1:0] md);
    bit               was_empty;
    bit               was_pend;
    bit               pop;
    logic [AW+DW-1:0] head;
    was_empty = (mq.size() == 0);
    was_pend  = m_pend;
    pop       = !was_empty && !mv;
    e_done    = 1'b0;
    // session tracking: opens on aux_vld, closes once everything has landed
    if (!e_busy) begin
      if (v) begin
        e_busy = 1'b1; m_closing = 1'b0; e_cnt = '0; e_ovf = 1'b0;
      end
    end else if (!m_closing) begin
      if (!v) m_closing = 1'b1;
    end else if (v) begin
      m_closing = 1'b0;
    end else if (was_empty && !was_pend) begin
      e_busy = 1'b0; e_done = 1'b1;
    end
    // write port
    m_pend = pop;
    e_we   = mv || pop;
    if (mv) begin
      e_addr = ma; e_data = md;
    end else if (pop) begin
      head = mq.pop_front();
      {e_addr, e_data} = head;
      e_cnt = e_cnt + 1'b1;
    end
    if (v && wv) begin
      if (mq.size() < DEPTH) mq.push_back({a, d});
      else e_ovf = 1'b1;
    end
  endtask

  task automatic tick(input logic v, input logic wv, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic mv,
                      input logic [AW-1:0] ma, input logic [DW-1:0] md);
    aux_vld = v; aux_write_vld = wv; aux_write_addr = a; aux_write_data = d;
    main_wr_vld = mv; main_wr_addr = ma; main_wr_data = md;
    @(posedge clk);
    model_step(v, wv, a, d, mv, ma, md);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (obs_vec() !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", obs_vec());
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_idle t=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_aux_burst();
    int dones = 0;
    for (int k = 0; k < 20; k++) begin
      tick(k < 8, k < 8, AW'(32'h100 + k), DW'(k), 1'b0, '0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL burst t=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (k >= 1 && k <= 8) begin
        checks++;
        if (buf_we !== 1'b1 || buf_addr !== AW'(32'h100 + k - 1) || buf_wdata !== DW'(k - 1)) begin
          failures++;
          $display("FAIL burst_latency t=%0d got we=%0b a=%h d=%h exp we=1 a=%h d=%h",
                   k, buf_we, buf_addr, buf_wdata, AW'(32'h100 + k - 1), k - 1);
        end
      end
      if (aux_done) dones++;
    end
    checks++;
    if (aux_wr_cnt !== CW'(8)) begin
      failures++;
      $display("FAIL burst_cnt got=%0d exp=8", aux_wr_cnt);
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL burst_done got=%0d pulses exp=1", dones);
    end
  endtask

  task automatic test_contention();
    int dones = 0;
    for (int k = 0; k < 40; k++) begin
      tick(k < 12, k < 12, AW'(32'h200 + k), DW'($urandom), k < 10, AW'($urandom), DW'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL contention t=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (aux_done) dones++;
    end
    checks++;
    if (aux_overflow !== 1'b0 || aux_wr_cnt !== CW'(12) || dones != 1) begin
      failures++;
      $display("FAIL contention_end got ovf=%0b cnt=%0d done=%0d exp ovf=0 cnt=12 done=1",
               aux_overflow, aux_wr_cnt, dones);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 60; k++) begin
      tick(k < 18, k < 18, AW'(32'h300 + k), DW'($urandom), k < 20, AW'($urandom), DW'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL overflow t=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (aux_overflow !== 1'b1 || aux_wr_cnt !== CW'(16)) begin
      failures++;
      $display("FAIL overflow_end got ovf=%0b cnt=%0d exp ovf=1 cnt=16", aux_overflow, aux_wr_cnt);
    end
    tick(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    checks++;
    if (aux_overflow !== 1'b0 || aux_wr_cnt !== '0 || aux_busy !== 1'b1) begin
      failures++;
      $display("FAIL overflow_clear got ovf=%0b cnt=%0d busy=%0b exp ovf=0 cnt=0 busy=1",
               aux_overflow, aux_wr_cnt, aux_busy);
    end
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL overflow_close t=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_full_pushpop();
    for (int k = 0; k < 40; k++) begin
      tick(k < 17, k < 17, AW'(32'h400 + k), DW'($urandom), k < 16, AW'($urandom), DW'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL full_pushpop t=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (aux_overflow !== 1'b0 || aux_wr_cnt !== CW'(17)) begin
      failures++;
      $display("FAIL full_pushpop_end got ovf=%0b cnt=%0d exp ovf=0 cnt=17", aux_overflow, aux_wr_cnt);
    end
  endtask

  task automatic test_merge();
    int dones = 0;
    for (int k = 0; k < 35; k++) begin
      tick((k < 4) || (k >= 6 && k < 9), (k < 4) || (k >= 6 && k < 9),
           AW'(32'h500 + k), DW'($urandom), k < 9, AW'($urandom), DW'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL merge t=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (aux_done) dones++;
    end
    checks++;
    if (aux_wr_cnt !== CW'(7) || dones != 1) begin
      failures++;
      $display("FAIL merge_end got cnt=%0d done=%0d exp cnt=7 done=1", aux_wr_cnt, dones);
    end
  endtask

  task automatic test_reset_mid();
    int we_seen = 0;
    for (int k = 0; k < 7; k++) begin
      tick(1'b1, k < 6, AW'(32'h600 + k), DW'($urandom), k >= 2, AW'($urandom), DW'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_mid_fill t=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (buf_we !== 1'b0 || aux_busy !== 1'b0 || aux_wr_cnt !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got we=%0b busy=%0b cnt=%0d exp 0 0 0", buf_we, aux_busy, aux_wr_cnt);
    end
    aux_vld = 1'b0; aux_write_vld = 1'b0; main_wr_vld = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_mid_after t=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (buf_we) we_seen++;
    end
    checks++;
    if (we_seen != 0) begin
      failures++;
      $display("FAIL reset_mid_stale got=%0d writes exp=0", we_seen);
    end
  endtask

  task automatic test_random();
    logic v     = 1'b0;
    int   mhold = 0;
    logic mv;
    for (int k = 0; k < 500; k++) begin
      if (k < 450) begin
        if ($urandom_range(0, 14) == 0) v = ~v;
        if ($urandom_range(0, 29) == 0) mhold = $urandom_range(5, 25);
        mv = (mhold > 0) || ($urandom_range(0, 9) < 2);
        if (mhold > 0) mhold--;
      end else begin
        v = 1'b0; mv = 1'b0;
      end
      tick(v, v && ($urandom_range(0, 9) < 6), AW'($urandom), DW'($urandom),
           mv, AW'($urandom), DW'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random t=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_aux_burst();
    test_contention();
    test_overflow();
    test_full_pushpop();
    test_merge();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
